// File: rtl/key_loader_pkg.sv
// key_loader_pkg: shared types and helpers for the key loader
package key_loader_pkg;

   typedef enum logic [2:0] {SHIFT, CHECK, SETTLE, READY, ERROR} state_t;

   function automatic int cnt_w(input int key_w);
      return $clog2(key_w + 1);
   endfunction

   function automatic logic parity(input logic [31:0] frame);
      return ^frame;
   endfunction

endpackage

// File: rtl/key_loader_if.sv
// key_loader_if: serial key beat stream with valid/ready handshake
interface key_loader_if;
   logic key_sdi;
   logic key_svalid;
   logic key_sready;
   modport master (output key_sdi, output key_svalid, input key_sready);
   modport slave (input key_sdi, input key_svalid, output key_sready);
endinterface

// File: rtl/key_shift_reg.sv
// key_shift_reg: serial-in frame register, LSB first, parity lands in the top bit
module key_shift_reg #(
   parameter int W = 2
) (
   input  logic         CK,
   input  logic         RN,
   input  logic         en,
   input  logic         clr,
   input  logic         sdi,
   output logic [W-1:0] key,
   output logic         par
);

   logic [W:0] sr;

   // new beats enter at the top so the first bit ends at index 0
   always_ff @(posedge CK or negedge RN)
      if (!RN) sr <= '0;
      else if (clr) sr <= '0;
      else if (en) sr <= {sdi, sr[W:1]};

   assign key = sr[W-1:0];
   assign par = sr[W];

endmodule

// File: rtl/key_loader.sv
// key_loader: receives a parity-checked serial key and drives the locked netlist key bus
module key_loader
   import key_loader_pkg::*;
#(
   parameter int             KEY_W      = 2,
   parameter logic [KEY_W-1:0] SAFE_KEY = '0,
   parameter int             SETTLE_CYC = 4
) (
   input  logic             CK,
   input  logic             RN,
   key_loader_if.slave      ks,
   input  logic             reload,
   output logic [KEY_W-1:0] keyinput,
   output logic             key_valid,
   output logic             key_err
);

   localparam int CW = cnt_w(KEY_W);

   state_t           state;
   logic [CW-1:0]    bcnt;
   logic [7:0]       scnt;
   logic [KEY_W-1:0] key;
   logic             par;
   logic             xfer;

   assign xfer = ks.key_svalid & ks.key_sready & ~reload;

   key_shift_reg #(.W(KEY_W)) u_sr (
      .CK  (CK),
      .RN  (RN),
      .en  (xfer),
      .clr (reload),
      .sdi (ks.key_sdi),
      .key (key),
      .par (par)
   );

   // frame sequencing, parity check, settle timing and registered outputs
   always_ff @(posedge CK or negedge RN)
      if (!RN) begin
         state         <= SHIFT;
         keyinput      <= SAFE_KEY;
         key_valid     <= 1'b0;
         key_err       <= 1'b0;
         ks.key_sready <= 1'b1;
         bcnt          <= '0;
         scnt          <= '0;
      end else if (reload) begin
         state         <= SHIFT;
         keyinput      <= SAFE_KEY;
         key_valid     <= 1'b0;
         key_err       <= 1'b0;
         ks.key_sready <= 1'b0;
         bcnt          <= '0;
      end else
         case (state)
            SHIFT: begin
               ks.key_sready <= 1'b1;
               if (xfer) begin
                  if (bcnt == CW'(KEY_W)) begin
                     state         <= CHECK;
                     bcnt          <= '0;
                     ks.key_sready <= 1'b0;
                  end else bcnt <= bcnt + CW'(1);
               end
            end
            CHECK: begin
               if (parity(32'({par, key}))) begin
                  state   <= ERROR;
                  key_err <= 1'b1;
               end else begin
                  state    <= SETTLE;
                  keyinput <= key;
                  scnt     <= 8'(SETTLE_CYC - 1);
               end
            end
            SETTLE: begin
               if (scnt == 8'd0) begin
                  state     <= READY;
                  key_valid <= 1'b1;
               end else scnt <= scnt - 8'd1;
            end
            default: ;
         endcase

endmodule

// File: tb/tb_key_loader.sv
// tb_key_loader: scoreboard bench for the serial key loader
module tb_key_loader;

   typedef struct packed {
      logic [1:0] key;
      logic       err;
   } exp_t;

   logic       CK = 1'b0;
   logic       RN = 1'b0;
   logic       reload = 1'b0;
   logic [1:0] keyinput;
   logic       key_valid;
   logic       key_err;
   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         t_par = 0;

   key_loader_if ks();

   key_loader #(.KEY_W(2), .SAFE_KEY(2'b00), .SETTLE_CYC(4)) dut (
      .CK        (CK),
      .RN        (RN),
      .ks        (ks),
      .reload    (reload),
      .keyinput  (keyinput),
      .key_valid (key_valid),
      .key_err   (key_err)
   );

   always #5 CK = ~CK;

   always @(posedge CK) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic send_beat(input logic b);
      int n = 0;
      ks.key_sdi = b;
      ks.key_svalid = 1'b1;
      while (ks.key_sready !== 1'b1 && n < 50) begin
         @(posedge CK);
         #1;
         n++;
      end
      if (n == 50) chk("sready_timeout", 32'(ks.key_sready), 1);
      @(posedge CK);
      #1;
      t_par = cyc;
      ks.key_svalid = 1'b0;
   endtask

   task automatic push_exp(input logic [1:0] k, input logic p);
      exp_t e;
      e.err = ^{p, k};
      e.key = e.err ? 2'b00 : k;
      sb.push_back(e);
   endtask

   task automatic frame(input logic [1:0] k, input logic p);
      send_beat(k[0]);
      send_beat(k[1]);
      send_beat(p);
      push_exp(k, p);
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      int n = 0;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 0, 1);
         return;
      end
      e = sb.pop_front();
      @(posedge CK);
      #1;
      chk({tag, "_key_t1"}, 32'(keyinput), 32'(e.key));
      chk({tag, "_valid_t1"}, 32'(key_valid), 0);
      while (!(key_valid || key_err) && n < 40) begin
         @(posedge CK);
         #1;
         n++;
      end
      chk({tag, "_key"}, 32'(keyinput), 32'(e.key));
      chk({tag, "_err"}, 32'(key_err), 32'(e.err));
      chk({tag, "_valid"}, 32'(key_valid), 32'(!e.err));
      chk({tag, "_lat"}, 32'(cyc - t_par), e.err ? 1 : 5);
      chk({tag, "_sready"}, 32'(ks.key_sready), 0);
   endtask

   task automatic do_reload(input string tag);
      reload = 1'b1;
      @(posedge CK);
      #1;
      reload = 1'b0;
      chk({tag, "_key"}, 32'(keyinput), 0);
      chk({tag, "_valid"}, 32'(key_valid), 0);
      chk({tag, "_err"}, 32'(key_err), 0);
      chk({tag, "_sready_lo"}, 32'(ks.key_sready), 0);
      @(posedge CK);
      #1;
      chk({tag, "_sready_hi"}, 32'(ks.key_sready), 1);
   endtask

   initial begin
      ks.key_sdi = 1'b0;
      ks.key_svalid = 1'b0;
      repeat (3) @(posedge CK);
      #3;
      chk("rst_key", 32'(keyinput), 0);
      chk("rst_valid", 32'(key_valid), 0);
      chk("rst_err", 32'(key_err), 0);
      RN = 1'b1;
      @(posedge CK);
      #1;
      chk("rel_sready", 32'(ks.key_sready), 1);
      chk("rel_key", 32'(keyinput), 0);
      chk("rel_valid", 32'(key_valid), 0);
      chk("rel_err", 32'(key_err), 0);

      frame(2'b01, 1'b1);
      check_result("good");
      repeat (3) @(posedge CK);
      #1;
      chk("good_hold_key", 32'(keyinput), 32'(2'b01));
      chk("good_hold_valid", 32'(key_valid), 1);

      do_reload("rl1");
      frame(2'b11, 1'b1);
      check_result("bad");
      repeat (3) @(posedge CK);
      #1;
      chk("bad_hold_key", 32'(keyinput), 0);
      chk("bad_hold_valid", 32'(key_valid), 0);
      chk("bad_hold_err", 32'(key_err), 1);
      do_reload("rl2");

      send_beat(1'b0);
      repeat (10) @(posedge CK);
      #1;
      chk("stall_sready", 32'(ks.key_sready), 1);
      send_beat(1'b1);
      send_beat(1'b1);
      push_exp(2'b10, 1'b1);
      check_result("stall");

      do_reload("rl3");
      send_beat(1'b1);
      send_beat(1'b0);
      send_beat(1'b1);
      @(posedge CK);
      #1;
      chk("mid_key", 32'(keyinput), 32'(2'b01));
      @(posedge CK);
      #1;
      reload = 1'b1;
      ks.key_sdi = 1'b1;
      ks.key_svalid = 1'b1;
      @(posedge CK);
      #1;
      reload = 1'b0;
      chk("mid_rl_key", 32'(keyinput), 0);
      chk("mid_rl_valid", 32'(key_valid), 0);
      chk("mid_rl_sready", 32'(ks.key_sready), 0);
      @(posedge CK);
      #1;
      ks.key_svalid = 1'b0;
      chk("mid_rl_sready_hi", 32'(ks.key_sready), 1);
      repeat (6) @(posedge CK);
      #1;
      chk("mid_rl_valid_hold", 32'(key_valid), 0);
      chk("mid_rl_key_hold", 32'(keyinput), 0);
      frame(2'b11, 1'b0);
      check_result("after_rl");

      #3;
      RN = 1'b0;
      #1;
      chk("arst_ready_key", 32'(keyinput), 0);
      chk("arst_ready_valid", 32'(key_valid), 0);
      chk("arst_ready_sready", 32'(ks.key_sready), 1);
      #2;
      RN = 1'b1;
      @(posedge CK);
      #1;

      send_beat(1'b1);
      #3;
      RN = 1'b0;
      #1;
      chk("arst_mid_key", 32'(keyinput), 0);
      chk("arst_mid_valid", 32'(key_valid), 0);
      chk("arst_mid_err", 32'(key_err), 0);
      chk("arst_mid_sready", 32'(ks.key_sready), 1);
      #1;
      RN = 1'b1;
      @(posedge CK);
      #1;
      frame(2'b11, 1'b0);
      check_result("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
